// File: rtl/sd_card_cmd_responder.sv
// Card-side SD CMD endpoint: receives 48-bit host commands, checks framing/CRC7, returns R1-R7 or R2 frames.
// Latency: cmd_valid one cycle after the end bit; start bit NCR cycles after resp_ack. No backpressure: waits in WAIT_RESP until resp_valid.
module sd_card_cmd_responder #(
  parameter int NCR = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         cmd_pin_in,
  output logic         cmd_pin_out,
  output logic         cmd_oe,
  output logic         cmd_valid,
  output logic [5:0]   cmd_index,
  output logic [31:0]  cmd_argument,
  output logic         crc_error,
  input  logic         resp_valid,
  input  logic [1:0]   resp_type,
  input  logic [5:0]   resp_index,
  input  logic [127:0] resp_data,
  output logic         resp_ack,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE,
    RX,
    CHECK,
    WAIT_RESP,
    NCR_WAIT,
    TX
  } state_t;

  state_t         state;
  logic [5:0]     rx_cnt;
  logic [45:0]    rx_sr;
  logic [6:0]     rx_crc;
  logic           tx_long;
  logic [135:0]   tx_sr;
  logic [6:0]     tx_crc;
  logic [7:0]     tx_cnt;
  logic [6:0]     ncr_cnt;

  logic [7:0]     tx_last;
  logic [7:0]     crc_lo;
  logic [7:0]     crc_hi;
  logic [7:0]     tx_n;
  logic           tx_in_data;
  logic           tx_in_crc;
  logic           tx_bit;
  logic           tx_emit;

  function automatic logic [6:0] crc7_step(input logic [6:0] c, input logic b);
    return {c[5:0], 1'b0} ^ ((b ^ c[6]) ? 7'h09 : 7'h00);
  endfunction

  // tx_n is the frame position about to be driven; the CRC field is produced from tx_crc.
  always_comb begin
    tx_last    = tx_long ? 8'd135 : 8'd47;
    crc_lo     = tx_long ? 8'd8   : 8'd0;
    crc_hi     = tx_long ? 8'd128 : 8'd40;
    tx_n       = (state == TX) ? (tx_cnt + 8'd1) : 8'd0;
    tx_in_data = (tx_n < crc_hi);
    tx_in_crc  = !tx_in_data && (tx_n < tx_last);
    tx_bit     = tx_in_data ? tx_sr[135] : (tx_in_crc ? tx_crc[6] : 1'b1);
    tx_emit    = ((state == NCR_WAIT) && (ncr_cnt == 7'd1)) ||
                 ((state == TX) && (tx_cnt != tx_last));
  end

  assign busy = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      cmd_pin_out  <= 1'b1;
      cmd_oe       <= 1'b0;
      cmd_valid    <= 1'b0;
      crc_error    <= 1'b0;
      resp_ack     <= 1'b0;
      cmd_index    <= 6'd0;
      cmd_argument <= 32'd0;
      rx_cnt       <= 6'd0;
      rx_sr        <= 46'd0;
      rx_crc       <= 7'd0;
      tx_long      <= 1'b0;
      tx_sr        <= 136'd0;
      tx_crc       <= 7'd0;
      tx_cnt       <= 8'd0;
      ncr_cnt      <= 7'd0;
    end else begin
      cmd_valid <= 1'b0;
      crc_error <= 1'b0;
      resp_ack  <= 1'b0;

      case (state)
        IDLE: begin
          if (!cmd_pin_in) begin
            rx_sr  <= 46'd0;
            rx_crc <= 7'd0;
            rx_cnt <= 6'd46;
            state  <= RX;
          end
        end

        RX: begin
          rx_sr <= {rx_sr[44:0], cmd_pin_in};
          if ((rx_cnt == 6'd46) && !cmd_pin_in) begin
            state <= IDLE;
          end else begin
            if (rx_cnt >= 6'd8) begin
              rx_crc <= crc7_step(rx_crc, cmd_pin_in);
            end
            if (rx_cnt == 6'd0) begin
              state <= CHECK;
            end else begin
              rx_cnt <= rx_cnt - 6'd1;
            end
          end
        end

        CHECK: begin
          if ((rx_sr[7:1] == rx_crc) && rx_sr[0]) begin
            cmd_index    <= rx_sr[45:40];
            cmd_argument <= rx_sr[39:8];
            cmd_valid    <= 1'b1;
            state        <= WAIT_RESP;
          end else begin
            crc_error <= 1'b1;
            state     <= IDLE;
          end
        end

        WAIT_RESP: begin
          if (resp_valid) begin
            resp_ack <= 1'b1;
            if ((resp_type == 2'b01) || (resp_type == 2'b10)) begin
              tx_long <= (resp_type == 2'b10);
              if (resp_type == 2'b10) begin
                tx_sr <= {8'h3F, resp_data[127:8], 8'd0};
              end else begin
                tx_sr <= {2'b00, resp_index, resp_data[31:0], 96'd0};
              end
              tx_crc  <= 7'd0;
              ncr_cnt <= 7'(NCR);
              state   <= NCR_WAIT;
            end else begin
              state <= IDLE;
            end
          end
        end

        NCR_WAIT: begin
          if (ncr_cnt == 7'd1) begin
            cmd_oe <= 1'b1;
            tx_cnt <= tx_n;
            state  <= TX;
          end else begin
            ncr_cnt <= ncr_cnt - 7'd1;
          end
        end

        TX: begin
          if (tx_cnt == tx_last) begin
            cmd_oe      <= 1'b0;
            cmd_pin_out <= 1'b1;
            state       <= IDLE;
          end else begin
            tx_cnt <= tx_n;
          end
        end

        default: state <= IDLE;
      endcase

      // Frame bits ahead of the CRC field come from tx_sr and feed the CRC as they leave.
      if (tx_emit) begin
        cmd_pin_out <= tx_bit;
        if (tx_in_data) begin
          tx_sr <= {tx_sr[134:0], 1'b0};
          if (tx_n >= crc_lo) begin
            tx_crc <= crc7_step(tx_crc, tx_bit);
          end
        end else if (tx_in_crc) begin
          tx_crc <= {tx_crc[5:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: tb/tb_sd_card_cmd_responder.sv
// Bench for sd_card_cmd_responder: two instances (NCR=2, NCR=64) share stimulus; a timeline model predicts every output.
module tb_sd_card_cmd_responder;
  localparam int MAXC = 32768;

  logic         clock = 1'b0;
  logic         reset;
  logic         cmd_pin_in;
  logic         resp_valid;
  logic [1:0]   resp_type;
  logic [5:0]   resp_index;
  logic [127:0] resp_data;
  logic [1:0]   pin_o, oe, vld, err, ack, bsy;
  logic [5:0]   idx [2];
  logic [31:0]  arg [2];

  always #5 clock = ~clock;

  sd_card_cmd_responder #(.NCR(2)) dut_a (
    .clock(clock), .reset(reset), .cmd_pin_in(cmd_pin_in),
    .cmd_pin_out(pin_o[0]), .cmd_oe(oe[0]), .cmd_valid(vld[0]),
    .cmd_index(idx[0]), .cmd_argument(arg[0]), .crc_error(err[0]),
    .resp_valid(resp_valid), .resp_type(resp_type), .resp_index(resp_index),
    .resp_data(resp_data), .resp_ack(ack[0]), .busy(bsy[0])
  );

  sd_card_cmd_responder #(.NCR(64)) dut_b (
    .clock(clock), .reset(reset), .cmd_pin_in(cmd_pin_in),
    .cmd_pin_out(pin_o[1]), .cmd_oe(oe[1]), .cmd_valid(vld[1]),
    .cmd_index(idx[1]), .cmd_argument(arg[1]), .crc_error(err[1]),
    .resp_valid(resp_valid), .resp_type(resp_type), .resp_index(resp_index),
    .resp_data(resp_data), .resp_ack(ack[1]), .busy(bsy[1])
  );

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Expected-output timeline indexed by edge number: value seen after that edge.
  bit          e_oe   [2][MAXC];
  bit          e_pin  [2][MAXC];
  bit          e_busy [2][MAXC];
  bit          e_vld  [MAXC];
  bit          e_err  [MAXC];
  bit          e_ack  [MAXC];
  bit          e_ld   [MAXC];
  bit          e_rst  [MAXC];
  logic [5:0]  e_ldi  [MAXC];
  logic [31:0] e_lda  [MAXC];
  int          ncr_of [2];

  int errors = 0;
  int checks = 0;
  logic [5:0]   cur_i = 6'd0;
  logic [31:0]  cur_a = 32'd0;
  logic [135:0] cap [2];
  int           ncap [2];

  task automatic chk(input string nm, input logic [135:0] act, input logic [135:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // CRC7 as the remainder of M(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] crc7(input logic [127:0] bits, input int n);
    logic [135:0] v;
    v = {8'd0, bits} << 7;
    for (int i = n + 6; i >= 7; i--) begin
      if (v[i]) v[i -: 8] = v[i -: 8] ^ 8'h89;
    end
    return v[6:0];
  endfunction

  function automatic logic [47:0] host_frame(input logic [5:0] ci, input logic [31:0] ca);
    logic [39:0] h;
    h = {2'b01, ci, ca};
    return {h, crc7({88'd0, h}, 40), 1'b1};
  endfunction

  function automatic logic [135:0] resp_frame(input logic [1:0] t, input logic [5:0] ri,
                                              input logic [127:0] rd);
    logic [39:0]  h;
    logic [119:0] c;
    if (t == 2'b10) begin
      c = rd[127:8];
      return {8'h3F, c, crc7({8'd0, c}, 120), 1'b1};
    end
    h = {2'b00, ri, rd[31:0]};
    return {88'd0, h, crc7({88'd0, h}, 40), 1'b1};
  endfunction

  always @(negedge clock) begin
    if (cyc >= 1 && cyc < MAXC) begin
      if (e_rst[cyc]) begin cur_i = 6'd0; cur_a = 32'd0; end
      if (e_ld[cyc])  begin cur_i = e_ldi[cyc]; cur_a = e_lda[cyc]; end
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("cmd_oe[%0d]", d),       oe[d],    e_oe[d][cyc]);
        chk($sformatf("cmd_pin_out[%0d]", d),  pin_o[d], e_pin[d][cyc]);
        chk($sformatf("busy[%0d]", d),         bsy[d],   e_busy[d][cyc]);
        chk($sformatf("cmd_valid[%0d]", d),    vld[d],   e_vld[cyc]);
        chk($sformatf("crc_error[%0d]", d),    err[d],   e_err[cyc]);
        chk($sformatf("resp_ack[%0d]", d),     ack[d],   e_ack[cyc]);
        chk($sformatf("cmd_index[%0d]", d),    idx[d],   cur_i);
        chk($sformatf("cmd_argument[%0d]", d), arg[d],   cur_a);
        if (oe[d] === 1'b1) begin
          cap[d] = {cap[d][134:0], pin_o[d]};
          ncap[d]++;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic noise_resp();
    resp_valid = 1'($urandom_range(0, 1));
    resp_type  = 2'($urandom);
    resp_index = 6'($urandom);
    resp_data  = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      cmd_pin_in = 1'b1;
      noise_resp();
      tick();
    end
  endtask

  task automatic set_busy(input int d, input int from, input int to);
    for (int k = from; k <= to; k++) if (k < MAXC) e_busy[d][k] = 1'b1;
  endtask

  // Drive one host frame and, when accepted, one response; optionally reset at TX bit 20 of rst_dut.
  task automatic run_cmd(input logic [47:0] f, input logic [1:0] rtype, input logic [5:0] ri,
                         input logic [127:0] rd, input int delay, input int rst_dut);
    int s, a, r, len, nb;
    bit pass, has_tx;
    logic [135:0] rf;
    s      = cyc + 1;
    nb     = f[46] ? 48 : 2;
    pass   = f[46] && f[0] && (f[7:1] == crc7({88'd0, f[47:8]}, 40));
    has_tx = (rtype == 2'b01) || (rtype == 2'b10);
    len    = (rtype == 2'b10) ? 136 : 48;
    rf     = resp_frame(rtype, ri, rd);
    a      = s + 49 + delay;
    r      = (rst_dut >= 0) ? a + ncr_of[rst_dut] + 21 : 0;

    if (!f[46]) begin
      for (int d = 0; d < 2; d++) set_busy(d, s, s);
    end else if (!pass) begin
      for (int d = 0; d < 2; d++) set_busy(d, s, s + 47);
      e_err[s + 48] = 1'b1;
    end else begin
      e_vld[s + 48] = 1'b1;
      e_ld[s + 48]  = 1'b1;
      e_ldi[s + 48] = f[45:40];
      e_lda[s + 48] = f[39:8];
      e_ack[a]      = 1'b1;
      for (int d = 0; d < 2; d++) begin
        set_busy(d, s, has_tx ? a + ncr_of[d] + len - 1 : a - 1);
        if (has_tx) begin
          for (int i = 0; i < len; i++) begin
            e_oe[d][a + ncr_of[d] + i]  = 1'b1;
            e_pin[d][a + ncr_of[d] + i] = rf[len - 1 - i];
          end
        end
      end
      if (rst_dut >= 0) begin
        e_rst[r] = 1'b1;
        for (int k = r; k < r + 300 && k < MAXC; k++) begin
          for (int d = 0; d < 2; d++) begin
            e_oe[d][k] = 1'b0; e_pin[d][k] = 1'b1; e_busy[d][k] = 1'b0;
          end
        end
      end
    end

    for (int i = 0; i < nb; i++) begin
      cmd_pin_in = f[47 - i];
      noise_resp();
      tick();
    end
    cmd_pin_in = 1'b1;
    if (!pass) return;

    noise_resp();
    cmd_pin_in = 1'($urandom_range(0, 1));
    tick();
    for (int j = 0; j < delay; j++) begin
      resp_valid = 1'b0;
      cmd_pin_in = 1'($urandom_range(0, 1));
      tick();
    end
    resp_valid = 1'b1;
    resp_type  = rtype;
    resp_index = ri;
    resp_data  = rd;
    cmd_pin_in = 1'($urandom_range(0, 1));
    tick();
    cap[0] = '0; cap[1] = '0; ncap[0] = 0; ncap[1] = 0;
    cmd_pin_in = 1'b1;
    noise_resp();

    if (rst_dut >= 0) begin
      while (cyc < r - 1) begin noise_resp(); tick(); end
      reset = 1'b1;
      tick();
      reset = 1'b0;
    end else if (has_tx) begin
      while (cyc < a + ncr_of[1] + len) begin noise_resp(); tick(); end
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("resp_frame[%0d]", d), cap[d], rf);
        chk($sformatf("oe_cycles[%0d]", d), 136'(ncap[d]), 136'(len));
      end
    end
  endtask

  logic [47:0]  f;
  logic [127:0] long_data;
  int           sel;

  initial begin
    ncr_of[0] = 2;
    ncr_of[1] = 64;
    for (int k = 0; k < MAXC; k++) begin
      e_pin[0][k] = 1'b1;
      e_pin[1][k] = 1'b1;
    end
    cap[0] = '0; cap[1] = '0; ncap[0] = 0; ncap[1] = 0;
    reset = 1'b1; cmd_pin_in = 1'b1; resp_valid = 1'b0;
    resp_type = 2'b00; resp_index = 6'd0; resp_data = '0;
    e_rst[1] = 1'b1; e_rst[2] = 1'b1; e_rst[3] = 1'b1;
    repeat (3) tick();
    reset = 1'b0;

    // Hand-computed anchors for the model itself.
    chk("model_crc_cmd0", 136'(crc7(128'h40_0000_0000, 40)), 136'h4A);
    chk("model_frame_cmd0", 136'(host_frame(6'd0, 32'd0)), 136'h400000000095);
    chk("model_frame_cmd8", 136'(host_frame(6'd8, 32'h1AA)), 136'h48000001AA87);
    chk("model_resp_r7", resp_frame(2'b01, 6'd8, 128'h1AA), 136'h08000001AA13);

    idle(4);
    run_cmd(48'h400000000095, 2'b00, 6'd0, '0, 0, -1);
    idle(2);
    chk("cmd0_index", 136'(idx[0]), 136'd0);
    chk("cmd0_argument", 136'(arg[0]), 136'd0);

    run_cmd(48'h48000001AA87, 2'b01, 6'd8, 128'h1AA, 2, -1);
    chk("cmd8_index", 136'(idx[0]), 136'd8);
    chk("cmd8_argument", 136'(arg[0]), 136'h1AA);
    chk("r7_on_pin", 136'(cap[0][47:0]), 136'h08000001AA13);
    idle(3);

    run_cmd(48'h48000001AA01, 2'b01, 6'd8, 128'h1AA, 0, -1);
    idle(3);
    run_cmd(48'h48000001AA86, 2'b01, 6'd8, 128'h1AA, 0, -1);
    idle(3);

    long_data = 128'h0123456789ABCDEF_FEDCBA9876543200;
    run_cmd(host_frame(6'd2, 32'd0), 2'b10, 6'd0, long_data, 1, -1);
    chk("long_fixed_ones", 136'(cap[0][133:128]), 136'h3F);
    idle(3);

    run_cmd(48'h080000000000, 2'b00, 6'd0, '0, 0, -1);
    idle(3);
    run_cmd(48'h400000000095, 2'b11, 6'd0, '0, 3, -1);
    idle(3);

    run_cmd(48'h48000001AA87, 2'b01, 6'd8, 128'h1AA, 0, 0);
    idle(2);
    run_cmd(48'h400000000095, 2'b00, 6'd0, '0, 1, -1);
    idle(2);
    run_cmd(host_frame(6'd55, 32'hDEADBEEF), 2'b01, 6'd55, 128'h12345678, 2, 1);
    idle(2);
    run_cmd(48'h400000000095, 2'b00, 6'd0, '0, 0, -1);
    idle(2);

    for (int t = 0; t < 30; t++) begin
      f   = host_frame(6'($urandom), $urandom);
      sel = $urandom_range(0, 9);
      if (sel == 0) f[7:1] = f[7:1] ^ 7'($urandom_range(1, 127));
      else if (sel == 1) f[0] = 1'b0;
      else if (sel == 2) f[46] = 1'b0;
      run_cmd(f, 2'($urandom), 6'($urandom), {$urandom, $urandom, $urandom, $urandom},
              $urandom_range(0, 4), -1);
      idle($urandom_range(1, 4));
    end

    idle(4);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
